// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver. Collects WIDTH framed serial bits,
// LSB-first or MSB-first, into a word and presents it on a held output
// register with a valid/ack handshake. A sticky overrun flag records any
// completed word that had to be dropped because the consumer had not
// taken the previous one.
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             lsb_first,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] Q,
  output logic             Q_valid,
  input  logic             Q_ack,
  output logic             busy,
  output logic             overrun
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;
  logic             lsb_latched;

  logic [WIDTH-1:0] shifted;
  logic             word_done;

  // Next shift-register value and frame-completion detect for this cycle.
  // NOTE: every signal is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shifted   = shift_reg;
    word_done = 1'b0;
    if (lsb_latched) begin
      shifted = {serial_in, shift_reg[WIDTH-1:1]};
    end else begin
      shifted = {shift_reg[WIDTH-2:0], serial_in};
    end
    // start in SHIFT restarts the frame, so it suppresses a completion on the same cycle.
    if (state == SHIFT && !start && serial_valid && count == LAST) begin
      word_done = 1'b1;
    end
  end

  // Frame FSM plus output register / handshake; every output is a flop.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      shift_reg   <= '0;
      count       <= '0;
      lsb_latched <= 1'b0;
      busy        <= 1'b0;
      Q           <= '0;
      Q_valid     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg   <= '0;
            count       <= '0;
            lsb_latched <= lsb_first;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (start) begin
            // Abort the partial frame and begin again with a fresh bit order.
            shift_reg   <= '0;
            count       <= '0;
            lsb_latched <= lsb_first;
          end else if (serial_valid) begin
            if (count == LAST) begin
              shift_reg <= '0;
              count     <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              shift_reg <= shifted;
              count     <= count + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Output handshake: the shift path never waits on the consumer.
      if (word_done) begin
        if (!Q_valid || Q_ack) begin
          Q       <= shifted;
          Q_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (Q_valid && Q_ack) begin
        Q_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer (WIDTH=4). Expected words are
// pushed to a scoreboard queue as the last bit of a frame is driven and
// popped when the DUT is due to present them.
module tb_serial_deserializer;

  localparam int WIDTH = 4;

  logic             clock;
  logic             resetn;
  logic             start;
  logic             lsb_first;
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] Q;
  logic             Q_valid;
  logic             Q_ack;
  logic             busy;
  logic             overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] exp_q[$];

  serial_deserializer #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .lsb_first    (lsb_first),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .Q            (Q),
    .Q_valid      (Q_valid),
    .Q_ack        (Q_ack),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input logic lsb);
    start     = 1'b1;
    lsb_first = lsb;
    tick();
    start     = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    tick();
    serial_valid = 1'b0;
  endtask

  task automatic do_ack();
    Q_ack = 1'b1;
    tick();
    Q_ack = 1'b0;
  endtask

  // bits[0] is sent first. accept: the word is expected to reach Q.
  // gap_at/gap_len: idle cycles inserted before bit index gap_at.
  task automatic send_bits(input string tag, input logic [3:0] bits, input logic [3:0] exp,
                           input bit accept, input bit ack_last, input int gap_at, input int gap_len);
    logic [3:0] want;
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          serial_valid = 1'b0;
          tick();
          check({tag, "_busy_gap"}, busy, 1);
        end
      end
      serial_in    = bits[i];
      serial_valid = 1'b1;
      if (i == 3) begin
        Q_ack = ack_last;
        if (accept) exp_q.push_back(exp);
      end
      tick();
      serial_valid = 1'b0;
      Q_ack        = 1'b0;
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid"}, Q_valid, 1);
    if (accept) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 0, 1);
      end else begin
        want = exp_q.pop_front();
        check({tag, "_q"}, Q, want);
      end
    end
  endtask

  task automatic send_frame(input string tag, input logic lsb, input logic [3:0] bits,
                            input logic [3:0] exp, input bit accept, input bit ack_last);
    start_frame(lsb);
    send_bits(tag, bits, exp, accept, ack_last, -1, 0);
  endtask

  task automatic hard_reset();
    #2;
    resetn = 1'b0;
    #4;
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    logic       lsb;
    logic [3:0] bits;
    logic [3:0] exp;

    resetn       = 1'b0;
    start        = 1'b0;
    lsb_first    = 1'b0;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    Q_ack        = 1'b0;
    #12;
    check("rst_q", Q, 0);
    check("rst_valid", Q_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    resetn = 1'b1;
    tick();

    // 1: LSB-first 1,0,1,1 -> D; ack clears valid, Q held.
    send_frame("t1", 1'b1, 4'b1101, 4'hD, 1, 0);
    do_ack();
    check("t1_ack_valid", Q_valid, 0);
    check("t1_ack_q", Q, 4'hD);

    // 2: MSB-first same bits with a 3-cycle idle gap -> B.
    start_frame(1'b0);
    send_bits("t2", 4'b1101, 4'hB, 1, 0, 2, 3);
    do_ack();
    check("t2_ack_valid", Q_valid, 0);

    // 3: second word dropped while first is unconsumed -> overrun sticky.
    send_frame("t3a", 1'b1, 4'b1101, 4'hD, 1, 0);
    send_frame("t3b", 1'b1, 4'b0000, 4'h0, 0, 0);
    check("t3_q_held", Q, 4'hD);
    check("t3_overrun", overrun, 1);
    do_ack();
    check("t3_ack_valid", Q_valid, 0);
    check("t3_overrun_sticky", overrun, 1);
    hard_reset();
    check("t3_overrun_cleared", overrun, 0);

    // 4: ack on the same edge the next word completes -> new word, no overrun.
    send_frame("t4a", 1'b1, 4'b1101, 4'hD, 1, 0);
    send_frame("t4b", 1'b1, 4'b0000, 4'h0, 1, 1);
    check("t4_overrun", overrun, 0);
    do_ack();

    // 5: restart after two partial bits, then 1,1,1,1 -> F.
    start_frame(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    start_frame(1'b1);
    send_bits("t5", 4'b1111, 4'hF, 1, 0, -1, 0);
    do_ack();

    // start coinciding with the 4th bit: start wins, no completion.
    start_frame(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    start        = 1'b1;
    lsb_first    = 1'b0;
    serial_in    = 1'b1;
    serial_valid = 1'b1;
    tick();
    start        = 1'b0;
    serial_valid = 1'b0;
    check("sw_valid", Q_valid, 0);
    check("sw_busy", busy, 1);
    check("sw_overrun", overrun, 0);
    check("sw_q_held", Q, 4'hF);
    // Re-latched as MSB-first: bits 0,0,1,1 -> 4'b0011.
    send_bits("sw", 4'b1100, 4'h3, 1, 0, -1, 0);
    do_ack();

    // 6: asynchronous reset mid-frame while Q_valid=1.
    send_frame("t6a", 1'b1, 4'b1101, 4'hD, 1, 0);
    start_frame(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_q", Q, 0);
    check("t6_valid", Q_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    #2;
    resetn = 1'b1;
    tick();
    send_frame("t6b", 1'b0, 4'b0110, 4'h6, 1, 0);
    do_ack();

    // Random frames in both bit orders, each acked.
    for (int k = 0; k < 8; k++) begin
      lsb  = 1'($urandom_range(0, 1));
      bits = 4'($urandom_range(0, 15));
      exp  = lsb ? bits : {bits[0], bits[1], bits[2], bits[3]};
      send_frame("rnd", lsb, bits, exp, 1, 0);
      do_ack();
      check("rnd_ack_valid", Q_valid, 0);
    end
    check("sb_drained", exp_q.size(), 0);
    check("final_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
